// File: rtl/booth_r4_mult_pipe.sv
// booth_r4_mult_pipe: pipelined radix-4 Booth multiplier with valid/ready flow control.
// Define BOOTH_OPERAND_ECHO_EN to add mx_q/my_q operand echo outputs.
module booth_r4_mult_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int CNTW   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mx,
    input  logic [WIDTH-1:0]     my,
    input  logic                 sgn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [CNTW-1:0]      inflight
`ifdef BOOTH_OPERAND_ECHO_EN
   ,output logic [WIDTH-1:0]     mx_q,
    output logic [WIDTH-1:0]     my_q
`endif
);
    localparam int ND = WIDTH / 2 + 1;
    localparam int PW = 2 * WIDTH;
    localparam int XW = WIDTH + 2;
    localparam int PS = (STAGES > 1) ? STAGES - 1 : 1;

    // Digit i is summed in this stage; stage 0 only sums when the pipe is one stage deep.
    function automatic int stage_of(input int i);
        return (STAGES == 1) ? 0 : 1 + (i * (STAGES - 1)) / ND;
    endfunction

    logic              w_adv, w_acc, w_hs;
    logic [STAGES-1:0] r_v, w_vin, w_ld;
    logic [PW-1:0]     r_acc [STAGES];
    logic [PW-1:0]     w_ain [STAGES];
    logic [PW-1:0]     w_sum [STAGES];
    logic [PW-1:0]     r_pp  [PS][ND];
    logic [ND-1:0]     r_neg [PS];
    logic [PW-1:0]     w_spp [STAGES][ND];
    logic [ND-1:0]     w_sng [STAGES];
    logic [PW-1:0]     w_pp  [ND];
    logic [ND-1:0]     w_neg;
    logic [XW-1:0]     w_xe, w_ye;
    logic [XW:0]       w_yz;
    logic [PW-1:0]     w_xp, w_m;
    logic [2:0]        w_t;
    logic [CNTW-1:0]   r_cnt;

    assign w_adv     = !r_v[STAGES-1] || out_ready;
    assign in_ready  = w_adv;
    assign w_acc     = in_valid && w_adv;
    assign w_hs      = r_v[STAGES-1] && out_ready;
    assign w_ld      = {STAGES{w_adv}} & w_vin;
    assign out_valid = r_v[STAGES-1];
    assign product   = r_acc[STAGES-1];
    assign inflight  = r_cnt;

    // Booth recoding; a negative digit contributes ~multiple here and its +1 joins the sum later.
    always_comb begin
        w_t   = '0;
        w_m   = '0;
        w_neg = '0;
        w_xe  = sgn ? {{2{mx[WIDTH-1]}}, mx} : {2'b00, mx};
        w_ye  = sgn ? {{2{my[WIDTH-1]}}, my} : {2'b00, my};
        w_yz  = {w_ye, 1'b0};
        w_xp  = {{(PW-XW){w_xe[XW-1]}}, w_xe};
        for (int i = 0; i < ND; i++) begin
            w_t      = w_yz[2*i +: 3];
            w_neg[i] = w_t[2] & ~(w_t[1] & w_t[0]);
            w_m      = (w_t[1] ^ w_t[0]) ? w_xp : (w_t == 3'b011 || w_t == 3'b100) ? w_xp << 1 : '0;
            w_pp[i]  = (w_neg[i] ? ~w_m : w_m) << (2 * i);
        end
    end

    always_comb begin
        w_vin[0] = in_valid;
        w_ain[0] = '0;
        w_sng[0] = w_neg;
        for (int i = 0; i < ND; i++) w_spp[0][i] = w_pp[i];
        for (int s = 1; s < STAGES; s++) begin
            w_vin[s] = r_v[s-1];
            w_ain[s] = r_acc[s-1];
            w_sng[s] = r_neg[s-1];
            for (int i = 0; i < ND; i++) w_spp[s][i] = r_pp[s-1][i];
        end
        for (int s = 0; s < STAGES; s++) begin
            w_sum[s] = w_ain[s];
            for (int i = 0; i < ND; i++)
                if (stage_of(i) == s)
                    w_sum[s] = w_sum[s] + w_spp[s][i] + (PW'(w_sng[s][i]) << (2 * i));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_v   <= '0;
            r_cnt <= '0;
            for (int s = 0; s < STAGES; s++) r_acc[s] <= '0;
        end else begin
            if (w_adv) r_v <= w_vin;
            r_cnt <= r_cnt + CNTW'(w_acc) - CNTW'(w_hs);
            for (int s = 0; s < STAGES; s++)
                if (w_ld[s]) r_acc[s] <= w_sum[s];
        end
    end

    // Partial products only need to travel as far as the stage that consumes the last of them.
    always_ff @(posedge CLK) begin
        for (int s = 0; s < STAGES - 1; s++)
            if (w_ld[s]) begin
                r_neg[s] <= w_sng[s];
                for (int i = 0; i < ND; i++) r_pp[s][i] <= w_spp[s][i];
            end
    end

`ifdef BOOTH_OPERAND_ECHO_EN
    logic [WIDTH-1:0] r_mxq [STAGES];
    logic [WIDTH-1:0] r_myq [STAGES];

    assign mx_q = r_mxq[STAGES-1];
    assign my_q = r_myq[STAGES-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < STAGES; s++) begin
                r_mxq[s] <= '0;
                r_myq[s] <= '0;
            end
        end else begin
            if (w_ld[0]) begin
                r_mxq[0] <= mx;
                r_myq[0] <= my;
            end
            for (int s = 1; s < STAGES; s++)
                if (w_ld[s]) begin
                    r_mxq[s] <= r_mxq[s-1];
                    r_myq[s] <= r_myq[s-1];
                end
        end
    end
`endif
endmodule
